// File: rtl/stage2_cordic.sv
// Vectoring-mode CORDIC: converts a Cartesian pair (M >= 0, N signed) into
// a gain-compensated magnitude and a Q2.10 angle, one micro-rotation per clock.
module stage2_cordic #(
    parameter int ITER  = 14,
    parameter int GUARD = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                validIn,
    input  logic [13:0]         M,
    input  logic signed [14:0]  N,
    output logic [15:0]         magMN,
    output logic signed [12:0]  atan,
    output logic                validOut
);

    // x/y carry GUARD fractional bits and enough headroom for the CORDIC gain
    localparam int XW     = 19 + GUARD;
    localparam int ZW     = 13;
    localparam int CW     = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int TDEPTH = 1 << CW;
    localparam int PW     = XW + 15;

    localparam logic [14:0]   GAIN       = 15'd19898;
    localparam logic [PW-1:0] ROUND_BIAS = PW'(1) << (14 + GUARD);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_SCALE = 2'd2;
    localparam logic [1:0] ST_LOAD  = 2'd3;

    function automatic logic signed [ZW-1:0] atan_lut(input int idx);
        case (idx)
            0:       atan_lut = 13'sd804;
            1:       atan_lut = 13'sd475;
            2:       atan_lut = 13'sd251;
            3:       atan_lut = 13'sd127;
            4:       atan_lut = 13'sd64;
            5:       atan_lut = 13'sd32;
            6:       atan_lut = 13'sd16;
            7:       atan_lut = 13'sd8;
            8:       atan_lut = 13'sd4;
            9:       atan_lut = 13'sd2;
            10:      atan_lut = 13'sd1;
            11:      atan_lut = 13'sd1;
            default: atan_lut = 13'sd0;
        endcase
    endfunction

    logic signed [ZW-1:0] atan_table [TDEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < TDEPTH; gi++) begin : g_table
            assign atan_table[gi] = atan_lut(gi);
        end
    endgenerate

    logic [1:0]           state_reg;
    logic [CW-1:0]        iter_reg;
    logic signed [XW-1:0] x_reg, y_reg;
    logic signed [ZW-1:0] z_reg;
    logic [PW-1:0]        prod_reg;
    logic                 zero_reg;
    logic [15:0]          mag_reg;
    logic signed [ZW-1:0] angle_reg;
    logic                 valid_reg;

    logic signed [XW-1:0] x_init, y_init;
    logic signed [XW-1:0] x_shift, y_shift;
    logic signed [XW-1:0] x_next, y_next;
    logic signed [ZW-1:0] z_next;
    logic signed [XW-1:0] x_pos;
    logic [PW-1:0]        prod_next;
    logic [PW-1:0]        mag_full;
    logic [15:0]          mag_sat;

    always_comb begin
        x_init = XW'(M) <<< GUARD;
        y_init = XW'(N) <<< GUARD;
    end

    // Micro-rotation drives y toward zero; every update uses the old x and y
    always_comb begin
        x_shift = x_reg >>> iter_reg;
        y_shift = y_reg >>> iter_reg;
        if (!y_reg[XW-1]) begin
            x_next = x_reg + y_shift;
            y_next = y_reg - x_shift;
            z_next = z_reg + atan_table[iter_reg];
        end else begin
            x_next = x_reg - y_shift;
            y_next = y_reg + x_shift;
            z_next = z_reg - atan_table[iter_reg];
        end
    end

    always_comb begin
        x_pos     = x_reg[XW-1] ? '0 : x_reg;
        prod_next = PW'($unsigned(x_pos)) * PW'(GAIN);
        mag_full  = (prod_reg + ROUND_BIAS) >> (15 + GUARD);
        mag_sat   = (|mag_full[PW-1:16]) ? 16'hFFFF : mag_full[15:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            iter_reg  <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            prod_reg  <= '0;
            zero_reg  <= 1'b0;
            mag_reg   <= '0;
            angle_reg <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (validIn) begin
                        x_reg     <= x_init;
                        y_reg     <= y_init;
                        z_reg     <= '0;
                        iter_reg  <= '0;
                        zero_reg  <= (M == 14'd0) && (N == 15'sd0);
                        state_reg <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    x_reg    <= x_next;
                    y_reg    <= y_next;
                    z_reg    <= z_next;
                    iter_reg <= iter_reg + CW'(1);
                    if (iter_reg == CW'(ITER - 1)) begin
                        state_reg <= ST_SCALE;
                    end
                end
                ST_SCALE: begin
                    prod_reg  <= prod_next;
                    state_reg <= ST_LOAD;
                end
                ST_LOAD: begin
                    // The zero vector would otherwise leave z at the sum of the table
                    mag_reg   <= zero_reg ? 16'd0 : mag_sat;
                    angle_reg <= zero_reg ? '0 : z_reg;
                    valid_reg <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign magMN    = mag_reg;
    assign atan     = angle_reg;
    assign validOut = valid_reg;

endmodule

// File: tb/tb_stage2_cordic.sv
// Directed bench for stage2_cordic: latency, accuracy windows, busy-ignore,
// back-to-back acceptance and mid-operation reset.
module tb_stage2_cordic;

    logic               clock = 1'b0;
    logic               reset;
    logic               validIn;
    logic [13:0]        M;
    logic signed [14:0] N;
    logic [15:0]        magMN;
    logic signed [12:0] atan;
    logic               validOut;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;

    stage2_cordic #(.ITER(14), .GUARD(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .validIn  (validIn),
        .M        (M),
        .N        (N),
        .magMN    (magMN),
        .atan     (atan),
        .validOut (validOut)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input int act, input int exp);
        n_assert++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int act, input int lo, input int hi);
        n_assert++;
        assert (act >= lo && act <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, act, lo, hi);
        end
    endtask

    task automatic start_op(input logic [13:0] m, input logic signed [14:0] n);
        M       = m;
        N       = n;
        validIn = 1'b1;
        tick();
        t0      = cyc;
        validIn = 1'b0;
        M       = 14'($urandom);
        N       = 15'($urandom);
    endtask

    task automatic wait_done(input string tag);
        while (!validOut && (cyc - t0) < 40) tick();
        chk({tag, " latency"}, cyc - t0, 16);
    endtask

    task automatic chk_result(input string tag, input int mexp, input int mtol,
                              input int aexp, input int atol, input bit pulse);
        chk({tag, " validOut"}, int'(validOut), 1);
        chk_range({tag, " mag"}, int'(magMN), mexp - mtol, mexp + mtol);
        chk_range({tag, " atan"}, int'(atan), aexp - atol, aexp + atol);
        if (pulse) begin
            tick();
            chk({tag, " pulse end"}, int'(validOut), 0);
            chk_range({tag, " mag hold"}, int'(magMN), mexp - mtol, mexp + mtol);
            chk_range({tag, " atan hold"}, int'(atan), aexp - atol, aexp + atol);
        end
    endtask

    initial begin
        reset   = 1'b1;
        validIn = 1'b0;
        M       = 14'd5850;
        N       = -15'sd1700;
        tick();
        reset = 1'b0;
        chk("reset mag", int'(magMN), 0);
        chk("reset atan", int'(atan), 0);
        chk("reset valid", int'(validOut), 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("idle valid", int'(validOut), 0);
            chk("idle mag", int'(magMN), 0);
        end

        start_op(14'd5850, -15'sd1700);
        wait_done("op 5850,-1700");
        chk_result("op 5850,-1700", 6092, 2, -290, 3, 1'b1);

        // A second strobe five cycles into the operation must be dropped
        start_op(14'd3000, 15'sd4000);
        repeat (4) tick();
        M = 14'd100; N = 15'sd100; validIn = 1'b1;
        tick();
        validIn = 1'b0;
        wait_done("busy ignore");
        chk_result("busy ignore", 5000, 2, 950, 3, 1'b1);
        repeat (20) tick();
        chk("no extra result", int'(validOut), 0);

        start_op(14'd16383, 15'sd0);
        wait_done("op 16383,0");
        chk_result("op 16383,0", 16383, 2, 0, 3, 1'b1);

        start_op(14'd0, 15'sd16383);
        wait_done("op 0,16383");
        chk_result("op 0,16383", 16383, 2, 1608, 3, 1'b1);

        start_op(14'd0, -15'sd16384);
        wait_done("op 0,-16384");
        chk_result("op 0,-16384", 16384, 2, -1608, 3, 1'b0);

        // Accepted on the first IDLE edge right after the validOut edge
        start_op(14'd0, 15'sd0);
        wait_done("b2b zero");
        chk_result("b2b zero", 0, 0, 0, 0, 1'b1);

        start_op(14'd3000, 15'sd4000);
        wait_done("op 3000,4000");
        chk_result("op 3000,4000", 5000, 2, 950, 3, 1'b1);

        // Reset at cycle 8 of an operation, with a coincident validIn
        start_op(14'd5850, -15'sd1700);
        repeat (7) tick();
        reset = 1'b1; validIn = 1'b1; M = 14'd3000; N = 15'sd4000;
        tick();
        reset = 1'b0; validIn = 1'b0;
        chk("mid reset mag", int'(magMN), 0);
        chk("mid reset atan", int'(atan), 0);
        for (int k = 0; k < 24; k++) begin
            tick();
            chk("after reset valid", int'(validOut), 0);
        end
        chk("after reset mag", int'(magMN), 0);
        chk("after reset atan", int'(atan), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
